// File: rtl/mac_dot_engine.sv
// Pipelined multiply-accumulate dot-product engine over framed operand streams.
// Latency: beat sampled at edge k is accumulated at edge k+1; result pulse follows (2 cycles).
// Backpressure: none; a beat is accepted on every cycle in_valid is high.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_first/in_last, a, b
//                            operand beat and its vector framing
//   out_valid                one-cycle pulse per completed vector
//   out_acc/out_ovf/out_count
//                            dot product, sticky overflow, term count (held until next result)
//   busy                     vector open or a beat waiting in stage 1
module mac_dot_engine #(
  parameter int DATA_W   = 4,
  parameter int ACC_W    = 16,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  localparam int PW  = 2 * DATA_W;
  localparam bit SGN = (SIGNED != 0);
  localparam bit SAT = (SATURATE != 0);

  // Stage 1 registers
  logic              s1_valid;
  logic              s1_first;
  logic              s1_last;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  // Stage 2 state
  logic [ACC_W-1:0]  acc;
  logic              ovf_sticky;
  logic [CNT_W-1:0]  cnt;
  logic              vec_open;

  // Stage 2 datapath
  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     b_ext;
  logic [PW-1:0]     prod;
  logic [ACC_W:0]    prod_x;
  logic [ACC_W:0]    base_x;
  logic [ACC_W:0]    sum;
  logic              ovf_now;
  logic [ACC_W-1:0]  sat_val;
  logic [ACC_W-1:0]  acc_nxt;
  logic              ovf_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  always_comb begin
    // Extending operands to the full product width before multiplying makes the
    // low PW bits of the product correct for both signed and unsigned operands.
    a_ext   = {{DATA_W{SGN & s1_a[DATA_W-1]}}, s1_a};
    b_ext   = {{DATA_W{SGN & s1_b[DATA_W-1]}}, s1_b};
    prod    = a_ext * b_ext;
    prod_x  = {{(ACC_W + 1 - PW){SGN & prod[PW-1]}}, prod};
    base_x  = s1_first ? '0 : {SGN & acc[ACC_W-1], acc};
    sum     = base_x + prod_x;

    // Both addends lie inside the ACC_W range, so one guard bit is enough:
    // unsigned overflow is a carry out, signed overflow is the guard bit
    // disagreeing with the result sign.
    ovf_now = SGN ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];

    if (!SGN)
      sat_val = '1;
    else if (sum[ACC_W])
      sat_val = {1'b1, {(ACC_W-1){1'b0}}};
    else
      sat_val = {1'b0, {(ACC_W-1){1'b1}}};

    acc_nxt = (ovf_now && SAT) ? sat_val : sum[ACC_W-1:0];
    ovf_nxt = ovf_now | (~s1_first & ovf_sticky);

    if (s1_first)
      cnt_nxt = CNT_W'(1);
    else if (&cnt)
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_first   <= 1'b0;
      s1_last    <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      cnt        <= '0;
      vec_open   <= 1'b0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_ovf    <= 1'b0;
      out_count  <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_first  <= in_first;
      s1_last   <= in_last;
      s1_a      <= a;
      s1_b      <= b;
      out_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        acc        <= acc_nxt;
        ovf_sticky <= ovf_nxt;
        cnt        <= cnt_nxt;
        // A vector only counts as open once a first beat has been seen.
        vec_open   <= ~s1_last & (s1_first | vec_open);
        if (s1_last) begin
          out_acc   <= acc_nxt;
          out_ovf   <= ovf_nxt;
          out_count <= cnt_nxt;
        end
      end
    end
  end

  assign busy = vec_open | s1_valid;

endmodule

// File: doc/mac_dot_engine.md
# mac_dot_engine

Parametrised, pipelined multiply-accumulate engine that computes dot products over framed operand streams. Each beat supplies one operand pair; `in_first`/`in_last` delimit a vector, and the engine emits one accumulated result per vector. It adds signed/unsigned mode, configurable operand and accumulator widths, saturation or wrap overflow handling, and a term counter. It sits between the operand input pins and the result output register of the MAC accelerator.

## Interface
- `DATA_W`, 4, operand width in bits (2..16)
- `ACC_W`, 16, accumulator and result width; must be ≥ 2*DATA_W
- `SIGNED`, 0, 1 = operands and accumulator are two's complement; 0 = unsigned
- `SATURATE`, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W
- `CNT_W`, 8, term-counter width
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  beat qualifier; `a`, `b`, `in_first` and `in_last` are ignored when low
- `in_first`  in  1  beat starts a new vector
- `in_last`  in  1  beat ends the current vector
- `a`, `b`  in  DATA_W each  operands
- `out_valid`  out  1  one-cycle pulse; result fields are valid
- `out_acc`  out  ACC_W  dot-product result
- `out_ovf`  out  1  an overflow occurred anywhere in this vector
- `out_count`  out  CNT_W  number of terms in this vector, saturating at 2^CNT_W-1
- `busy`  out  1  a vector is open (first seen, last not yet accumulated) or stage 1 holds a valid beat

## Operation
- No backpressure: a beat is accepted on every cycle in which `in_valid`=1.
- Stage 1 (S1) registers `a`, `b`, `in_first`, `in_last` and `in_valid`.
- Stage 2 (S2):
  - Computes the full 2*DATA_W-bit product. In SIGNED mode the operands are sign-extended before the multiply and the product is sign-extended to ACC_W.
  - Base value: 0 if the S1 first flag is set, otherwise the current accumulator.
  - Sum is computed at ACC_W+1 bits, then checked for overflow:
    - Unsigned overflow: sum > 2^ACC_W-1.
    - Signed overflow: sum outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - On overflow: SATURATE=1 clamps to the nearest bound; SATURATE=0 keeps the low ACC_W bits. The sticky overflow flag is set in both modes.
  - The first flag clears the sticky overflow flag and resets the term count to 1; otherwise the count increments and saturates at its maximum.
- When the S2 beat carries last: on the same edge, `out_acc`, `out_ovf` and `out_count` load the post-update values and `out_valid` is high for the following cycle. The accumulator keeps its value.
- Cycle with no valid beat: the accumulator, flags and count hold.
- A valid beat without `in_first` after reset or after a last accumulates onto the held accumulator. After reset this value is 0.
- `in_first` and `in_last` asserted on the same beat form a single-term vector; the result is the product alone.
- `in_first` arriving mid-vector discards the partial sum and starts a new vector. No output is produced for the discarded partial vector.

## Timing
- Reset values: `out_valid`=0, `out_acc`=0, `out_ovf`=0, `out_count`=0, `busy`=0; the accumulator, sticky flag, count and S1 valid are also 0.
- Latency: a beat sampled at edge k is accumulated at edge k+1. If that beat is last, `out_valid` is high in the cycle after edge k+1 (2 cycles from input).
- Throughput: 1 beat per cycle. Back-to-back vectors are allowed: a last at cycle t may be followed by a first at t+1. Results then appear in consecutive cycles.
- `out_*` fields hold their value until the next result. `out_valid` is high for exactly one cycle per last.
- `rst` asserted mid-vector clears all state at that edge. In-flight beats are dropped, and no `out_valid` is produced for them, including in the cycle after reset.

## Test plan
- Unsigned, defaults. Beats (3,5) first, (2,7), (15,15) last on consecutive cycles -> one `out_valid` pulse 2 cycles after the last beat, with `out_acc`=254, `out_count`=3, `out_ovf`=0.
- Single-beat vector (15,15) with first and last asserted, then (1,2),(3,4) with `in_valid` bubbles between beats -> results 225 (count 1), then 14 (count 2). Bubbles do not change results or add pulses.
- ACC_W=8, SATURATE=1. Beats (15,15) first, (15,15) last -> `out_acc`=255, `out_ovf`=1. Same stimulus with SATURATE=0 -> `out_acc`=194, `out_ovf`=1. A following vector (1,1) first+last -> 1, `out_ovf`=0.
- SIGNED=1, DATA_W=4. Beats (-8,7) first, (-8,-8) last -> `out_acc`=8. With ACC_W=8, SATURATE=1, four beats (-8,-8) -> 127, `out_ovf`=1; four beats (-8,7) -> -128, `out_ovf`=1.
- Back-to-back vectors [(2,3) first+last], [(4,4) first, (1,1) last] -> `out_valid` pulses carry 6, then 17. A first inserted mid-vector discards the partial sum.
- Assert `rst` for 1 cycle after two beats of an open vector -> all outputs 0 and no `out_valid` pulse. The next vector (1,1) first+last -> `out_acc`=1, `out_count`=1.
